// File: rtl/wordcount_pkg.sv
// Shared constants and FSM encoding for the word-count write-back path.
package wordcount_pkg;

    localparam int BEAT_BYTES       = 64;
    localparam int ENTRY_BITS       = 64;
    localparam int ENTRIES_PER_BEAT = 8;

    typedef enum logic [2:0] {
        WB_IDLE,
        WB_SETUP,
        WB_START,
        WB_STREAM,
        WB_WAIT_DONE
    } wb_state_t;

endpackage

// File: rtl/beat_packer.sv
// Packs 64-bit accumulator reads into 512-bit beats and drives the AXIS output register.
module beat_packer
    import wordcount_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rd_issue,
    input  logic                  rd_last,
    input  logic [ENTRY_BITS-1:0] rd_dout,
    output logic                  lane_free,
    output logic                  tvalid,
    input  logic                  tready,
    output logic [511:0]          tdata,
    output logic                  tlast
);
    localparam logic [3:0] FULL = 4'(ENTRIES_PER_BEAT);

    logic [RD_LATENCY-1:0] vld_sr;
    logic [RD_LATENCY-1:0] last_sr;
    logic [511:0]          pack_data;
    logic [3:0]            fill;
    logic                  pack_last;
    logic [3:0]            resv;
    logic [3:0]            resv_after;
    logic                  capture;
    logic                  move;

    // resv counts lanes promised to reads in flight plus lanes already holding data
    always_comb begin
        capture    = vld_sr[RD_LATENCY-1];
        move       = ((fill == FULL) || pack_last) && (!tvalid || tready);
        resv_after = resv - (move ? fill : 4'd0);
        lane_free  = resv_after < FULL;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_sr    <= '0;
            last_sr   <= '0;
            pack_data <= '0;
            fill      <= '0;
            pack_last <= 1'b0;
            resv      <= '0;
            tvalid    <= 1'b0;
            tdata     <= '0;
            tlast     <= 1'b0;
        end else begin
            vld_sr[0]  <= rd_issue;
            last_sr[0] <= rd_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
            resv <= resv_after + {3'd0, rd_issue};
            // clearing on move is what zero-pads the lanes of a short final beat
            if (move) begin
                pack_data <= '0;
                fill      <= '0;
                pack_last <= 1'b0;
            end else if (capture) begin
                pack_data[int'(fill[2:0]) * ENTRY_BITS +: ENTRY_BITS] <= rd_dout;
                fill      <= fill + 4'd1;
                pack_last <= last_sr[RD_LATENCY-1];
            end
            if (move) begin
                tvalid <= 1'b1;
                tdata  <= pack_data;
                tlast  <= pack_last;
            end else if (tready) begin
                tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/accum_writeback_ctrl.sv
// Streams accumulator counters to host memory in page-sized bursts, one ctrl_start per page.
// States: IDLE wait kick | SETUP size page | START pulse ctrl_start | STREAM read+pack | WAIT_DONE await ctrl_done
module accum_writeback_ctrl
    import wordcount_pkg::*;
#(
    parameter int WRITE_PAGESIZE   = 4096,
    parameter int ACCUM_RD_LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         kick,
    output logic         busy,
    input  logic [31:0]  num_of_entries,
    input  logic [63:0]  memory_offset,
    output logic         ctrl_start,
    input  logic         ctrl_done,
    output logic [63:0]  ctrl_addr_offset,
    output logic [31:0]  ctrl_xfer_size_in_bytes,
    output logic         s_axis_tvalid,
    input  logic         s_axis_tready,
    output logic [511:0] s_axis_tdata,
    output logic         s_axis_tlast,
    output logic [31:0]  accum_rd_addr,
    output logic         accum_rd_en,
    input  logic [63:0]  accum_rd_dout
);
    localparam logic [31:0] PAGE_ENTRIES = 32'(WRITE_PAGESIZE / (ENTRY_BITS / 8));
    localparam logic [63:0] PAGE_BYTES   = 64'(WRITE_PAGESIZE);

    wb_state_t   state, state_next;
    logic [31:0] entries_left;
    logic [31:0] page_entries;
    logic [31:0] page_issued;
    logic [63:0] page_addr;
    logic [31:0] rd_ptr;
    logic        done_seen;
    logic        lane_free;
    logic        rd_issue;
    logic        rd_last;
    logic        last_beat_done;
    logic        kick_ok;
    logic [31:0] page_len;

    always_comb begin
        state_next     = state;
        kick_ok        = (state == WB_IDLE) && kick;
        page_len       = (entries_left < PAGE_ENTRIES) ? entries_left : PAGE_ENTRIES;
        rd_issue       = (state == WB_STREAM) && (page_issued != page_entries) && lane_free;
        rd_last        = rd_issue && (page_issued == page_entries - 32'd1);
        last_beat_done = s_axis_tvalid && s_axis_tready && s_axis_tlast;
        unique case (state)
            WB_IDLE:      if (kick) state_next = WB_SETUP;
            WB_SETUP:     state_next = (entries_left == '0) ? WB_IDLE : WB_START;
            WB_START:     state_next = WB_STREAM;
            WB_STREAM:    if (last_beat_done) state_next = WB_WAIT_DONE;
            WB_WAIT_DONE: if (done_seen || ctrl_done)
                              state_next = (entries_left == '0) ? WB_IDLE : WB_SETUP;
            default:      state_next = WB_IDLE;
        endcase
    end

    assign accum_rd_en   = rd_issue;
    assign accum_rd_addr = rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= WB_IDLE;
            busy                    <= 1'b0;
            ctrl_start              <= 1'b0;
            ctrl_addr_offset        <= '0;
            ctrl_xfer_size_in_bytes <= '0;
            entries_left            <= '0;
            page_entries            <= '0;
            page_issued             <= '0;
            page_addr               <= '0;
            rd_ptr                  <= '0;
            done_seen               <= 1'b0;
        end else begin
            state      <= state_next;
            busy       <= kick_ok || (state != WB_IDLE);
            ctrl_start <= (state == WB_START);
            if (kick_ok) begin
                entries_left <= num_of_entries;
                page_addr    <= memory_offset;
                rd_ptr       <= '0;
            end
            if (state == WB_SETUP) begin
                page_entries <= page_len;
                page_issued  <= '0;
            end
            // address and size change only together with the ctrl_start pulse
            if (state == WB_START) begin
                ctrl_addr_offset        <= page_addr;
                ctrl_xfer_size_in_bytes <= ((page_entries + 32'd7) >> 3) * 32'(BEAT_BYTES);
                page_addr               <= page_addr + PAGE_BYTES;
                entries_left            <= entries_left - page_entries;
            end
            if (rd_issue) begin
                rd_ptr      <= rd_ptr + 32'd1;
                page_issued <= page_issued + 32'd1;
            end
            if (state == WB_START)
                done_seen <= 1'b0;
            else if (ctrl_done)
                done_seen <= 1'b1;
        end
    end

    beat_packer #(
        .RD_LATENCY (ACCUM_RD_LATENCY)
    ) u_beat_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_issue  (rd_issue),
        .rd_last   (rd_last),
        .rd_dout   (accum_rd_dout),
        .lane_free (lane_free),
        .tvalid    (s_axis_tvalid),
        .tready    (s_axis_tready),
        .tdata     (s_axis_tdata),
        .tlast     (s_axis_tlast)
    );

endmodule

// File: tb/tb_accum_writeback_ctrl.sv
// Self-checking bench: page/beat model derived from entry counts, accumulator memory model, directed tests.
module tb_accum_writeback_ctrl;
    localparam int LAT  = 2;
    localparam int PAGE = 4096;
    localparam int PE   = PAGE / 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         kick = 1'b0;
    logic         busy;
    logic [31:0]  num_of_entries = '0;
    logic [63:0]  memory_offset = '0;
    logic         ctrl_start;
    logic         ctrl_done = 1'b0;
    logic [63:0]  ctrl_addr_offset;
    logic [31:0]  ctrl_xfer_size_in_bytes;
    logic         s_axis_tvalid;
    logic         s_axis_tready = 1'b0;
    logic [511:0] s_axis_tdata;
    logic         s_axis_tlast;
    logic [31:0]  accum_rd_addr;
    logic         accum_rd_en;
    logic [63:0]  accum_rd_dout;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    accum_writeback_ctrl #(
        .WRITE_PAGESIZE   (PAGE),
        .ACCUM_RD_LATENCY (LAT)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .kick                    (kick),
        .busy                    (busy),
        .num_of_entries          (num_of_entries),
        .memory_offset           (memory_offset),
        .ctrl_start              (ctrl_start),
        .ctrl_done               (ctrl_done),
        .ctrl_addr_offset        (ctrl_addr_offset),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .s_axis_tvalid           (s_axis_tvalid),
        .s_axis_tready           (s_axis_tready),
        .s_axis_tdata            (s_axis_tdata),
        .s_axis_tlast            (s_axis_tlast),
        .accum_rd_addr           (accum_rd_addr),
        .accum_rd_en             (accum_rd_en),
        .accum_rd_dout           (accum_rd_dout)
    );

    // accumulator memory: value is a pure function of the address
    bit pat_wide = 1'b0;
    function automatic logic [63:0] acc_val(input longint unsigned idx);
        logic [31:0] a;
        a = 32'(idx);
        return pat_wide ? {~a, a + 32'd1} : {32'd0, a + 32'd1};
    endfunction

    logic [31:0] pipe_addr [LAT];
    logic        pipe_vld  [LAT];
    always @(posedge clk) begin
        pipe_addr[0] <= accum_rd_addr;
        pipe_vld[0]  <= accum_rd_en;
        for (int i = 1; i < LAT; i++) begin
            pipe_addr[i] <= pipe_addr[i-1];
            pipe_vld[i]  <= pipe_vld[i-1];
        end
    end
    assign accum_rd_dout = pipe_vld[LAT-1] ? acc_val(64'(pipe_addr[LAT-1])) : 64'hDEAD_BEEF_DEAD_BEEF;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_w(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // model state for the current transfer
    int              m_total, m_next, m_page, m_starts, m_dones, m_reads, beat_no;
    longint unsigned m_offset;
    int              busy_cycles, first_start_cyc, first_busy_cyc, kick_cyc;
    bit              mon_en = 1'b0, rand_ready = 1'b0;
    int              max_delay = 0, done_timer = 0;
    logic [511:0]    first_beat;
    int              tlast_beats [$];
    longint unsigned start_addrs [$];
    longint unsigned start_sizes [$];
    logic            prev_v = 1'b0, prev_r = 1'b0;
    logic [511:0]    prev_d;

    task automatic monitor_step();
        int page_end, n;
        logic [511:0] e;
        longint unsigned left, pe, exp_size;
        if (busy) begin
            busy_cycles++;
            if (first_busy_cyc < 0) first_busy_cyc = int'(cyc);
        end
        if (accum_rd_en) begin
            chk("rd_addr", accum_rd_addr, 64'(m_reads));
            m_reads++;
        end
        if (ctrl_start) begin
            left     = 64'(m_total - m_starts * PE);
            pe       = (left < 64'(PE)) ? left : 64'(PE);
            exp_size = (pe + 7) / 8 * 64;
            chk("start_addr", ctrl_addr_offset, m_offset + 64'(m_starts) * 64'(PAGE));
            chk("start_size", ctrl_xfer_size_in_bytes, exp_size);
            chk("start_after_done", 64'(m_dones), 64'(m_starts));
            if (m_starts == 0) first_start_cyc = int'(cyc);
            start_addrs.push_back(ctrl_addr_offset);
            start_sizes.push_back(64'(ctrl_xfer_size_in_bytes));
            m_starts++;
        end
        if (prev_v && !prev_r) begin
            chk("hold_valid", s_axis_tvalid, 1);
            chk_w("hold_data", s_axis_tdata, prev_d);
        end
        if (s_axis_tvalid) begin
            chk("valid_after_start", m_starts > m_page, 1);
            if (s_axis_tready) begin
                page_end = ((m_page + 1) * PE < m_total) ? (m_page + 1) * PE : m_total;
                n = (page_end - m_next < 8) ? page_end - m_next : 8;
                chk("beat_expected", m_next < m_total, 1);
                e = '0;
                for (int j = 0; j < n; j++) e[64*j +: 64] = acc_val(64'(m_next + j));
                chk_w("beat_data", s_axis_tdata, e);
                chk("beat_last", s_axis_tlast, (m_next + n) == page_end);
                if (beat_no == 0) first_beat = s_axis_tdata;
                if (s_axis_tlast) begin
                    tlast_beats.push_back(beat_no);
                    done_timer = (rand_ready ? int'($urandom_range(0, max_delay)) : 0) + 1;
                end
                if (n > 0) m_next += n;
                if (m_next >= page_end) m_page++;
                beat_no++;
            end
        end
        prev_v = s_axis_tvalid;
        prev_r = s_axis_tready;
        prev_d = s_axis_tdata;
    endtask

    // drives tready / ctrl_done for the coming edge, then checks outputs mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            s_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            ctrl_done = 1'b0;
            if (!reset_n) done_timer = 0;
            else if (done_timer > 0) begin
                done_timer--;
                if (done_timer == 0) begin
                    ctrl_done = 1'b1;
                    m_dones++;
                end
            end
            #1;
            if (reset_n && mon_en) monitor_step();
        end
    end

    task automatic kick_start(input int num, input longint unsigned off);
        m_total = num; m_offset = off; m_next = 0; m_page = 0; m_starts = 0; m_dones = 0;
        m_reads = 0; beat_no = 0; busy_cycles = 0; first_start_cyc = -1; first_busy_cyc = -1;
        tlast_beats.delete(); start_addrs.delete(); start_sizes.delete();
        first_beat = '0; prev_v = 1'b0; mon_en = 1'b1;
        @(negedge clk);
        num_of_entries = 32'(num);
        memory_offset  = off;
        kick           = 1'b1;
        kick_cyc       = int'(cyc);
        @(negedge clk);
        kick           = 1'b0;
        num_of_entries = 32'd5;
        memory_offset  = 64'hFFFF_0000_FFFF_0000;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || n < 3) && n < 20000);
        chk({name, "_timeout"}, n < 20000, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_single_beat_8(input string name);
        chk({name, "_starts"}, 64'(m_starts), 1);
        chk({name, "_addr"}, start_addrs.size() > 0 ? start_addrs[0] : 64'hFFFF, 64'h1000);
        chk({name, "_size"}, start_sizes.size() > 0 ? start_sizes[0] : 64'hFFFF, 64);
        chk({name, "_beats"}, 64'(beat_no), 1);
        chk({name, "_tlast_beat"}, tlast_beats.size() > 0 ? 64'(tlast_beats[0]) : 64'hFFFF, 0);
        chk({name, "_lane0"}, first_beat[63:0], 1);
        chk({name, "_lane7"}, first_beat[511:448], 8);
        chk({name, "_start_latency"}, 64'(first_start_cyc - kick_cyc), 3);
        chk({name, "_busy_latency"}, 64'(first_busy_cyc - kick_cyc), 1);
        chk({name, "_reads"}, 64'(m_reads), 8);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_tvalid", s_axis_tvalid, 0);
        chk("rst_ctrl_start", ctrl_start, 0);
        chk("rst_rd_en", accum_rd_en, 0);
        chk_w("rst_tdata", s_axis_tdata, '0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: one full beat
        kick_start(8, 64'h1000);
        wait_idle("t1");
        check_single_beat_8("t1");

        // 2: short beat, zero-padded lanes
        kick_start(3, 64'h0);
        wait_idle("t2");
        chk("t2_size", start_sizes.size() > 0 ? start_sizes[0] : 64'hFFFF, 64);
        chk("t2_lane0", first_beat[63:0], 1);
        chk("t2_lane1", first_beat[127:64], 2);
        chk("t2_lane2", first_beat[191:128], 3);
        chk_w("t2_pad", {192'd0, first_beat[511:192]}, '0);
        chk("t2_tlast_beat", tlast_beats.size() > 0 ? 64'(tlast_beats[0]) : 64'hFFFF, 0);

        // 3: three pages
        kick_start(1100, 64'h0);
        wait_idle("t3");
        chk("t3_starts", 64'(m_starts), 3);
        chk("t3_addr1", start_addrs.size() > 1 ? start_addrs[1] : 64'hFFFF, 64'h1000);
        chk("t3_addr2", start_addrs.size() > 2 ? start_addrs[2] : 64'hFFFF, 64'h2000);
        chk("t3_size0", start_sizes.size() > 0 ? start_sizes[0] : 64'hFFFF, 4096);
        chk("t3_size2", start_sizes.size() > 2 ? start_sizes[2] : 64'hFFFF, 640);
        chk("t3_tlast0", tlast_beats.size() > 0 ? 64'(tlast_beats[0]) : 64'hFFFF, 63);
        chk("t3_tlast1", tlast_beats.size() > 1 ? 64'(tlast_beats[1]) : 64'hFFFF, 127);
        chk("t3_tlast2", tlast_beats.size() > 2 ? 64'(tlast_beats[2]) : 64'hFFFF, 137);
        chk("t3_entries", 64'(m_next), 1100);

        // 4: random backpressure, delayed ctrl_done, address wrap across pages
        pat_wide = 1'b1; rand_ready = 1'b1; max_delay = 200;
        kick_start(600, 64'hFFFF_FFFF_FFFF_F000);
        wait_idle("t4");
        chk("t4_entries", 64'(m_next), 600);
        chk("t4_reads", 64'(m_reads), 600);
        chk("t4_starts", 64'(m_starts), 2);
        chk("t4_wrap_addr", start_addrs.size() > 1 ? start_addrs[1] : 64'hFFFF, 64'h0);
        pat_wide = 1'b0; rand_ready = 1'b0; max_delay = 0;

        // 5: zero entries
        kick_start(0, 64'h4000);
        wait_idle("t5");
        chk("t5_starts", 64'(m_starts), 0);
        chk("t5_reads", 64'(m_reads), 0);
        chk("t5_busy_cycles", 64'(busy_cycles), 2);
        chk("t5_beats", 64'(beat_no), 0);

        // 6: reset in the middle of page 2, then a clean single-beat transfer
        kick_start(1100, 64'h0);
        n = 0;
        while (!(m_page == 1 && m_next >= 560) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reach_page2", n < 5000, 1);
        @(negedge clk);
        reset_n = 1'b0;
        mon_en  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("t6_rst_busy", busy, 0);
            chk("t6_rst_tvalid", s_axis_tvalid, 0);
            chk("t6_rst_ctrl_start", ctrl_start, 0);
            chk("t6_rst_rd_en", accum_rd_en, 0);
            chk("t6_rst_addr", ctrl_addr_offset, 0);
            @(negedge clk);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        kick_start(8, 64'h1000);
        wait_idle("t6");
        check_single_beat_8("t6");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
